clk_div_sel_ctrl: RTL and testbench
===================================

# clk_div_sel_ctrl

Divide-ratio controller for the counter clock-divider path. Keeps one free-running 4-bit divide counter and drives a single registered divided-clock output at /2, /4, /8 or /16 of `clk`. Ratio changes are requested over a req/ack handshake and applied only at the counter wrap point, so the output never glitches or produces a short pulse. Sits between control logic and downstream logic that consumes the divided clock or its `tick` enable.

## Interface
- `DEF_SEL`, 2'd0, ratio code loaded on reset (0=/2, 1=/4, 2=/8, 3=/16)
- `clk`  in  1  system clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req`  in  1  ratio-change request, sampled only when `busy`=0
- `sel`  in  2  requested ratio code, sampled with `req`
- `ack`  out 1  one-cycle pulse: the requested ratio is now active
- `busy` out 1  request accepted, not yet acknowledged
- `cur_sel` out 2  ratio code currently driving `div_out`
- `div_out` out 1  registered divided clock, 50% duty
- `tick` out 1  one-cycle pulse in the first `clk` cycle where `div_out` is high

## Operation
- `cnt[3:0]` increments by 1 every `clk` edge and wraps 15→0. It is never held or cleared except by reset.
- `div_out` is registered as `div_out <= cnt_next[active_sel_next]`. Bit k of the counter gives divide-by 2^(k+1).
- `tick` is registered as `tick <= cnt_next[active_sel_next] & ~div_out`.
- `cur_sel` equals the `active_sel` register.
- FSM states:
  - **IDLE**: `busy`=0. If `req`=1 and `sel`==`active_sel`, latch nothing and go to ACK. If `req`=1 and `sel`!=`active_sel`, latch `pend_sel`<=`sel` and go to WAIT.
  - **WAIT**: `busy`=1. At each edge where the pre-edge `cnt`==15, load `active_sel`<=`pend_sel` (so `cnt` becomes 0 on the same edge) and go to ACK. Otherwise stay in WAIT.
  - **ACK**: `busy`=1 and `ack`=1 for exactly one cycle, then IDLE.
- `req` is ignored in WAIT and ACK. A request is never queued. The requester must hold `req` or re-issue it after `busy` falls.
- Glitch-free rule: at the switch edge every counter bit goes to 0, so `div_out` goes low (or stays low) for both the old and the new ratio. Under the old ratio, the last high phase before the switch is always full length.
- A request accepted at an edge where `cnt`==15 does not switch on that edge. It waits for the next wrap, 16 edges later.
- `ack` and `busy` are state decodes of registered state only. No combinational path from `req`.

## Timing
- Reset (`rst`=0), asynchronous and immediate:
  - `cnt`=0, `active_sel`=`DEF_SEL`, `pend_sel`=`DEF_SEL`, state=IDLE.
  - `div_out`=0, `tick`=0, `ack`=0, `busy`=0, `cur_sel`=`DEF_SEL`.
- Reset release: the first rising edge after `rst` goes high increments `cnt` to 1.
- Reset asserted during WAIT or ACK aborts the request and returns everything to reset values. No `ack` is issued.
- Same-ratio request: `req` sampled at edge E0 → `ack`=1 and `busy`=1 during the cycle after E0, and both are 0 after E0+1.
- Different-ratio request sampled at E0:
  - `busy`=1 from E0.
  - The switch happens at the first edge Es > E0 with pre-edge `cnt`==15. Es−E0 is between 1 and 16.
  - `ack`=1 in the cycle after Es. `busy` falls at Es+1.
- New ratio on `div_out`: the first high level appears after edge Es + 2^`active_sel` (for example, Es+4 for /8).
- `tick` rises on the same edge as `div_out` rises and lasts one cycle.

## Test plan
- **Reset/default**: hold `rst`=0 for 3 cycles, then release with `DEF_SEL`=0.
  - During reset all outputs are 0 except `cur_sel`=0.
  - After release `div_out` toggles every edge (period 2 `clk`).
  - `tick` is high every other cycle.
- **Switch /2→/8 mid-count**: pulse `req` with `sel`=2 when `cnt`=5.
  - `busy` is high 10 cycles, then `ack` pulses once.
  - `cur_sel`=2 from the `cnt` 15→0 edge.
  - `div_out` is then 4 low / 4 high, with no high pulse shorter than 1 old-ratio half-period.
- **Same-ratio request**: with `cur_sel`=2, pulse `req` with `sel`=2.
  - `ack` is high in the next cycle and `busy` is high only that cycle.
  - `div_out` phase is unchanged.
- **Busy collision**: accept `sel`=3, then 2 cycles later pulse `req` with `sel`=1.
  - The second request is ignored and only one `ack` is issued.
  - Final `cur_sel`=3 with a 16-cycle `div_out` period.
- **Request at `cnt`=15**: `req` with `sel`=1 sampled at an edge where `cnt`=15.
  - No switch on that edge.
  - The switch happens 16 edges later and `ack` follows one cycle after it.
- **Reset mid-WAIT**: assert `rst` 3 cycles after accepting `sel`=3.
  - All outputs return immediately to reset values.
  - No `ack` is seen after release, and `cur_sel`=`DEF_SEL`.

Source files
------------

// File: rtl/clk_div_sel_ctrl.sv
// Divide-ratio controller: free-running 4-bit counter drives a /2../16 divided clock.
// Ratio changes arrive over req/ack and take effect only at the counter wrap, so div_out never glitches.
module clk_div_sel_ctrl #(
  parameter logic [1:0] DEF_SEL = 2'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [1:0] sel,
  output logic       ack,
  output logic       busy,
  output logic [1:0] cur_sel,
  output logic       div_out,
  output logic       tick
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [SEL_W-1:0]   active_sel, active_sel_nxt;
  logic [SEL_W-1:0]   pend_sel, pend_sel_nxt;
  logic               div_nxt;
  logic               tick_nxt;

  // Next-state and next-output decode.
  always_comb begin
    state_nxt      = state;
    active_sel_nxt = active_sel;
    pend_sel_nxt   = pend_sel;
    cnt_nxt        = cnt + CNT_W'(1);

    case (state)
      ST_IDLE: begin
        if (req) begin
          if (sel == active_sel) begin
            state_nxt = ST_ACK;
          end else begin
            pend_sel_nxt = sel;
            state_nxt    = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Switch only on the wrap edge: every counter bit lands at 0 for old and new ratio alike.
        if (cnt == CNT_W'(15)) begin
          active_sel_nxt = pend_sel;
          state_nxt      = ST_ACK;
        end
      end
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    div_nxt  = cnt_nxt[active_sel_nxt];
    tick_nxt = div_nxt & ~div_out;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      active_sel <= DEF_SEL;
      pend_sel   <= DEF_SEL;
      div_out    <= 1'b0;
      tick       <= 1'b0;
      ack        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      active_sel <= active_sel_nxt;
      pend_sel   <= pend_sel_nxt;
      div_out    <= div_nxt;
      tick       <= tick_nxt;
      ack        <= (state_nxt == ST_ACK);
      busy       <= (state_nxt != ST_IDLE);
    end
  end

  assign cur_sel = active_sel;

endmodule

// File: tb/tb_clk_div_sel_ctrl.sv
// Directed bench for clk_div_sel_ctrl: reset, ratio switch, same-ratio, collision, wrap-edge request, reset abort.
module tb_clk_div_sel_ctrl;

  logic       clk;
  logic       rst;
  logic       req;
  logic [1:0] sel;
  logic       ack;
  logic       busy;
  logic [1:0] cur_sel;
  logic       div_out;
  logic       tick;

  int checks   = 0;
  int failures = 0;
  logic [3:0] ecnt;   // expected counter value after the most recent edge

  clk_div_sel_ctrl #(.DEF_SEL(2'd0)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .sel     (sel),
    .ack     (ack),
    .busy    (busy),
    .cur_sel (cur_sel),
    .div_out (div_out),
    .tick    (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    ecnt = ecnt + 4'd1;
  endtask

  task automatic advance_to(input logic [3:0] target);
    while (ecnt != target) step();
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 1'b0; sel = 2'd0; ecnt = 4'd0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if ({div_out, tick, ack, busy, cur_sel} !== 6'b0) begin
        failures++;
        $display("FAIL reset_outputs got div=%b tick=%b ack=%b busy=%b cur=%0d exp all 0", div_out, tick, ack, busy, cur_sel);
      end
    end
    rst = 1'b1;
    ecnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (div_out !== ecnt[0] || tick !== ecnt[0]) begin
        failures++;
        $display("FAIL div2_toggle cnt=%0d got div=%b tick=%b exp div=%b tick=%b", ecnt, div_out, tick, ecnt[0], ecnt[0]);
      end
    end
  endtask

  task automatic test_switch_2_to_8();
    advance_to(4'd5);
    req = 1'b1; sel = 2'd2;
    step();                          // E0, pre-edge cnt 5
    req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (busy !== 1'b1 || ack !== 1'b0 || cur_sel !== 2'd0 || div_out !== ecnt[0]) begin
        failures++;
        $display("FAIL sw8_wait cnt=%0d got busy=%b ack=%b cur=%0d div=%b exp 1 0 0 %b", ecnt, busy, ack, cur_sel, div_out, ecnt[0]);
      end
      step();
    end
    checks++;
    if (ecnt !== 4'd0 || ack !== 1'b1 || busy !== 1'b1 || cur_sel !== 2'd2 || div_out !== 1'b0) begin
      failures++;
      $display("FAIL sw8_ack cnt=%0d got ack=%b busy=%b cur=%0d div=%b exp 1 1 2 0", ecnt, ack, busy, cur_sel, div_out);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (ack !== 1'b0 || busy !== 1'b0 || div_out !== ecnt[2] || tick !== (ecnt == 4'd4 || ecnt == 4'd12)) begin
        failures++;
        $display("FAIL sw8_div cnt=%0d got ack=%b busy=%b div=%b tick=%b exp 0 0 %b %b", ecnt, ack, busy, div_out, tick, ecnt[2], (ecnt == 4'd4 || ecnt == 4'd12));
      end
    end
  endtask

  task automatic test_same_ratio();
    advance_to(4'd9);
    req = 1'b1; sel = 2'd2;
    step();
    req = 1'b0;
    checks++;
    if (ack !== 1'b1 || busy !== 1'b1 || cur_sel !== 2'd2 || div_out !== ecnt[2]) begin
      failures++;
      $display("FAIL same_ack got ack=%b busy=%b cur=%0d div=%b exp 1 1 2 %b", ack, busy, cur_sel, div_out, ecnt[2]);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (ack !== 1'b0 || busy !== 1'b0 || div_out !== ecnt[2]) begin
        failures++;
        $display("FAIL same_after cnt=%0d got ack=%b busy=%b div=%b exp 0 0 %b", ecnt, ack, busy, div_out, ecnt[2]);
      end
    end
  endtask

  task automatic test_busy_collision();
    int acks;
    acks = 0;
    advance_to(4'd3);
    req = 1'b1; sel = 2'd3;
    step();                          // accepted, cnt 4
    req = 1'b0;
    step();
    req = 1'b1; sel = 2'd1;          // sampled at the next edge, while in WAIT
    step();
    req = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ack === 1'b1) begin
        acks++;
        checks++;
        if (ecnt !== 4'd0 || cur_sel !== 2'd3) begin
          failures++;
          $display("FAIL coll_ack_point got cnt=%0d cur=%0d exp 0 3", ecnt, cur_sel);
        end
      end
      step();
    end
    checks++;
    if (acks != 1) begin
      failures++;
      $display("FAIL coll_ack_count got %0d exp 1", acks);
    end
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (cur_sel !== 2'd3 || busy !== 1'b0 || div_out !== ecnt[3] || tick !== (ecnt == 4'd8)) begin
        failures++;
        $display("FAIL coll_div16 cnt=%0d got cur=%0d busy=%b div=%b tick=%b exp 3 0 %b %b", ecnt, cur_sel, busy, div_out, tick, ecnt[3], (ecnt == 4'd8));
      end
    end
  endtask

  task automatic test_req_at_wrap();
    advance_to(4'd15);
    req = 1'b1; sel = 2'd1;
    step();                          // pre-edge cnt 15: accepted, no switch
    req = 1'b0;
    checks++;
    if (ecnt !== 4'd0 || busy !== 1'b1 || ack !== 1'b0 || cur_sel !== 2'd3) begin
      failures++;
      $display("FAIL wrap_accept got cnt=%0d busy=%b ack=%b cur=%0d exp 0 1 0 3", ecnt, busy, ack, cur_sel);
    end
    for (int i = 0; i < 15; i++) begin
      step();
      checks++;
      if (busy !== 1'b1 || ack !== 1'b0 || cur_sel !== 2'd3) begin
        failures++;
        $display("FAIL wrap_wait cnt=%0d got busy=%b ack=%b cur=%0d exp 1 0 3", ecnt, busy, ack, cur_sel);
      end
    end
    step();                          // 16th edge after acceptance
    checks++;
    if (ack !== 1'b1 || cur_sel !== 2'd1 || div_out !== 1'b0) begin
      failures++;
      $display("FAIL wrap_switch got ack=%b cur=%0d div=%b exp 1 1 0", ack, cur_sel, div_out);
    end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (ack !== 1'b0 || busy !== 1'b0 || div_out !== ecnt[1]) begin
        failures++;
        $display("FAIL wrap_div4 cnt=%0d got ack=%b busy=%b div=%b exp 0 0 %b", ecnt, ack, busy, div_out, ecnt[1]);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    advance_to(4'd2);
    req = 1'b1; sel = 2'd3;
    step();
    req = 1'b0;
    repeat (3) step();               // cnt 6: div_out high under /4
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({div_out, tick, ack, busy} !== 4'b0 || cur_sel !== 2'd0) begin
      failures++;
      $display("FAIL rst_async got div=%b tick=%b ack=%b busy=%b cur=%0d exp 0 0 0 0 0", div_out, tick, ack, busy, cur_sel);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    ecnt = 4'd0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (ack !== 1'b0 || busy !== 1'b0 || cur_sel !== 2'd0 || div_out !== ecnt[0]) begin
        failures++;
        $display("FAIL rst_after cnt=%0d got ack=%b busy=%b cur=%0d div=%b exp 0 0 0 %b", ecnt, ack, busy, cur_sel, div_out, ecnt[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_switch_2_to_8();
    test_same_ratio();
    test_busy_collision();
    test_req_at_wrap();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
